// File: rtl/chan_mux_rr_pkg.sv
// Shared definitions for the channel mux: mode encoding and a clog2 helper
// used to size the channel-index buses.
package chan_mux_rr_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Ceiling log2, never below 1 so a 2-channel mux still has a 1-bit index.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chan_mux_rr_arb.sv
// Round-robin arbiter. Holds the last granted channel and searches forward
// from the channel after it, wrapping modulo NCH, for the first requester.
module rr_arb
  import chan_mux_rr_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int SW  = clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [SW-1:0]  grant,
  output logic           grant_valid
);

  logic [SW-1:0] r_lastGrant;

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(r_lastGrant) + k) % NCH;
      if (!grant_valid && req[idx]) begin
        grant       = SW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  // Pointer resets to the top channel so channel 0 wins first; it only moves on a granted RR transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lastGrant <= SW'(NCH - 1);
    end else if (advance) begin
      r_lastGrant <= grant;
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// NCH-to-1 valid/ready channel mux with manual or round-robin selection and
// a one-entry registered output stage.
module chan_mux_rr
  import chan_mux_rr_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int W   = 8,
  localparam int SW  = clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             rr_en,
  input  logic [SW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [W-1:0]  r_outData;
  logic [SW-1:0] r_outChan;
  logic          r_outValid;

  logic          w_load;
  logic          w_rrMode;
  logic [SW-1:0] w_rrGrant;
  logic          w_rrGrantValid;
  logic          w_manGrantValid;
  logic [SW-1:0] w_grant;
  logic          w_grantValid;
  logic          w_xfer;
  logic [W-1:0]  w_selData;

  assign w_load   = ~r_outValid | out_ready;
  assign w_rrMode = (rr_en == MODE_RR);
  assign w_xfer   = rst_n & w_load & w_grantValid;

  rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (in_valid),
    .advance    (w_xfer & w_rrMode),
    .grant      (w_rrGrant),
    .grant_valid(w_rrGrantValid)
  );

  // Manual path grants only the selected channel, and never an out-of-range index.
  always_comb begin
    w_manGrantValid = 1'b0;
    if (int'(sel) < NCH) begin
      w_manGrantValid = in_valid[sel];
    end
  end

  // Mode mux between arbiter result and the manual select.
  always_comb begin
    w_grant      = sel;
    w_grantValid = w_manGrantValid;
    if (w_rrMode) begin
      w_grant      = w_rrGrant;
      w_grantValid = w_rrGrantValid;
    end
  end

  // One-hot ready to the granted channel, held low during reset and backpressure.
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  // Pick the granted channel's data slice.
  always_comb begin
    w_selData = in_data[int'(w_grant)*W +: W];
  end

  // Output register: capture on transfer, empty on load without grant, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outChan  <= '0;
      r_outValid <= 1'b0;
    end else if (w_load) begin
      if (w_grantValid) begin
        r_outData  <= w_selData;
        r_outChan  <= w_grant;
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_data  = r_outData;
  assign out_chan  = r_outChan;
  assign out_valid = r_outValid;

endmodule
